// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: func3 codes, FSM states and size helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ACCESS2 = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Stores have no unsigned variants, so BU/HU encodings are only legal for loads.
    function automatic logic func3_legal(input logic write, input logic [2:0] func3);
        if (write)
            return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
        return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
               (func3 == F3_BU) || (func3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the (possibly two-word) read data down to the access offset and extends it per func3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    input  logic [63:0] rdata,
    output logic [31:0] result
);

    logic [31:0] x;

    always_comb begin
        x = 32'(rdata >> {off, 3'b000});
        case (func3)
            F3_B:    result = {{24{x[7]}}, x[7:0]};
            F3_BU:   result = {24'h0, x[7:0]};
            F3_H:    result = {{16{x[15]}}, x[15:0]};
            F3_HU:   result = {16'h0, x[15:0]};
            default: result = x;
        endcase
    end

endmodule

// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer between the memory stage and a req/ack data-memory port.
// Define LSU_MISALIGNED_SPLIT_EN to run word-crossing accesses as two beats instead of faulting.
module lsu_access_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    lsu_state_t  state;
    logic        write_q;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic        split_q;
    logic        fault_q;
    logic [7:0]  wait_cnt;
    logic [3:0]  strb2_q;
    logic [31:0] wdata2_q;
    logic [31:0] rdata_lo_q;
    logic [31:0] rdata_hi_q;
    logic [31:0] load_result;

    logic [3:0]  acc_mask;
    logic [7:0]  acc_strb;
    logic [63:0] acc_wdata;
    logic        acc_split;
    logic        acc_fault;
    logic        timed_out;

    // Lanes are computed 8 bytes wide so the upper half is ready-made for a second beat.
    always_comb begin
        acc_mask  = size_mask(req_func3);
        acc_strb  = {4'b0000, acc_mask} << req_addr[1:0];
        acc_wdata = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
        acc_split = (req_func3[1:0] == 2'b01 && req_addr[1:0] == 2'b11) ||
                    (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        acc_fault = !func3_legal(req_write, req_func3);
`else
        acc_split = 1'b0;
        acc_fault = !func3_legal(req_write, req_func3) ||
                    (req_func3[1:0] == 2'b01 && req_addr[0]) ||
                    (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`endif
        timed_out = (wait_cnt + 8'd1) == TIMEOUT_LIMIT;
    end

    lsu_load_align u_align (
        .off    (off_q),
        .func3  (func3_q),
        .rdata  ({rdata_hi_q, rdata_lo_q}),
        .result (load_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_fault  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            write_q    <= 1'b0;
            func3_q    <= '0;
            off_q      <= '0;
            split_q    <= 1'b0;
            fault_q    <= 1'b0;
            wait_cnt   <= '0;
            strb2_q    <= '0;
            wdata2_q   <= '0;
            rdata_lo_q <= '0;
            rdata_hi_q <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_data  <= '0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        write_q    <= req_write;
                        func3_q    <= req_func3;
                        off_q      <= req_addr[1:0];
                        split_q    <= acc_split;
                        strb2_q    <= req_write ? acc_strb[7:4] : 4'b0000;
                        wdata2_q   <= req_write ? acc_wdata[63:32] : 32'h0;
                        rdata_lo_q <= '0;
                        rdata_hi_q <= '0;
                        wait_cnt   <= '0;
                        fault_q    <= acc_fault;
                        if (acc_fault) begin
                            state <= RESP;
                        end else begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wstrb <= req_write ? acc_strb[3:0] : 4'b0000;
                            mem_wdata <= req_write ? acc_wdata[31:0] : 32'h0;
                        end
                    end
                end
                ACCESS, ACCESS2: begin
                    if (mem_ack) begin
                        wait_cnt <= '0;
                        if (state == ACCESS2) begin
                            rdata_hi_q <= mem_rdata;
                            mem_req    <= 1'b0;
                            state      <= RESP;
                        end else if (split_q) begin
                            // Second beat keeps mem_req high; the address wraps naturally at 2^32.
                            rdata_lo_q <= mem_rdata;
                            mem_addr   <= mem_addr + 32'd4;
                            mem_wstrb  <= strb2_q;
                            mem_wdata  <= wdata2_q;
                            state      <= ACCESS2;
                        end else begin
                            rdata_lo_q <= mem_rdata;
                            mem_req    <= 1'b0;
                            state      <= RESP;
                        end
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        fault_q <= 1'b1;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= fault_q;
                    rsp_data  <= (fault_q || write_q) ? 32'h0 : load_result;
                    mem_we    <= 1'b0;
                    mem_wstrb <= '0;
                    mem_wdata <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Scoreboard bench for lsu_access_sequencer: requests push expected responses, a monitor pops them.
`timescale 1ns/1ps
module tb_lsu_access_sequencer;

    localparam int TIMEOUT = 6;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ack_r;
    logic        force_ack;

    assign mem_ack = ack_r | force_ack;

    lsu_access_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          latency;
        int          accept;
    } exp_t;

    exp_t exp_q[$];

    logic        cfg_check;
    logic        cfg_we;
    logic        cfg_noack;
    logic [31:0] cfg_addr[2];
    logic [3:0]  cfg_strb[2];
    logic [31:0] cfg_wdata[2];
    int          cfg_wait[2];
    logic [31:0] cfg_rdata[2];
    int          beat;
    int          wait_cnt;
    int          req_cycles;
    logic        beat_checked;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Memory responder: checks each beat's request once, then acks after the configured wait count.
    always @(negedge clk) begin
        ack_r = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        if (!reset && mem_req) begin
            req_cycles++;
            if (beat < 2) begin
                if (!beat_checked && cfg_check) begin
                    checkOutput("mem_addr", mem_addr, cfg_addr[beat]);
                    checkOutput("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, cfg_strb[beat]});
                    checkOutput("mem_we", {31'h0, mem_we}, {31'h0, cfg_we});
                    if (cfg_we)
                        checkOutput("mem_wdata", mem_wdata, cfg_wdata[beat]);
                end
                beat_checked = 1'b1;
                if (!cfg_noack && wait_cnt == cfg_wait[beat]) begin
                    ack_r = 1'b1;
                    mem_rdata = cfg_rdata[beat];
                    beat++;
                    wait_cnt = 0;
                    beat_checked = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected 0");
            end else begin
                e = exp_q.pop_front();
                checkOutput("rsp_data", rsp_data, e.data);
                checkOutput("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.fault});
                checkOutput("rsp_latency", cycle - e.accept, e.latency);
            end
        end
    end

    task automatic setMem(input logic check, input logic we, input logic noack,
                          input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                          input int w0, input logic [31:0] r0);
        cfg_check = check;
        cfg_we = we;
        cfg_noack = noack;
        cfg_addr[0] = a0;
        cfg_strb[0] = s0;
        cfg_wdata[0] = d0;
        cfg_wait[0] = w0;
        cfg_rdata[0] = r0;
        cfg_addr[1] = a0 + 32'd4;
        cfg_strb[1] = 4'h0;
        cfg_wdata[1] = 32'h0;
        cfg_wait[1] = 0;
        cfg_rdata[1] = 32'h0;
        beat = 0;
        wait_cnt = 0;
        req_cycles = 0;
        beat_checked = 1'b0;
    endtask

`ifdef LSU_MISALIGNED_SPLIT_EN
    task automatic setBeat2(input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                            input int w1, input logic [31:0] r1);
        cfg_addr[1] = a1;
        cfg_strb[1] = s1;
        cfg_wdata[1] = d1;
        cfg_wait[1] = w1;
        cfg_rdata[1] = r1;
    endtask
`endif

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_data,
                                 input logic exp_fault, input int exp_lat, output int acc);
        int guard = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_func3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: got req_ready=0, expected 1");
        end
        @(negedge clk);
        acc = cycle;
        exp_q.push_back('{exp_data, exp_fault, exp_lat, acc});
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rsp_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic runAccess(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_data,
                             input logic exp_fault, input int exp_lat, input int exp_req_cycles);
        int acc;
        applyStimulus(wr, f3, addr, wdata, exp_data, exp_fault, exp_lat, acc);
        waitIdle();
        checkOutput("mem_req_cycles", req_cycles, exp_req_cycles);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc1;
        int acc2;
        reset = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_func3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        force_ack = 1'b0;
        ack_r = 1'b0;
        mem_rdata = 32'h0;
        setMem(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("reset_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        checkOutput("reset_rsp_data", rsp_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] LB / SH / LHU with waits");
        setMem(1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h80FF_0000);
        runAccess(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1);
        setMem(1'b1, 1'b1, 1'b0, 32'h200, 4'b1100, 32'hBEEF_0000, 0, 32'h5555_5555);
        runAccess(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0, 1'b0, 2, 1);
        setMem(1'b1, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 5, 32'h1234_ABCD);
        runAccess(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_ABCD, 1'b0, 7, 6);

        $display("[TB] timeout and illegal func3");
        setMem(1'b1, 1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 0, 32'h0);
        runAccess(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b1, TIMEOUT + 1, TIMEOUT);
        setMem(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
        runAccess(1'b0, 3'b011, 32'h30, 32'h0, 32'h0, 1'b1, 1, 0);
        setMem(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
        runAccess(1'b1, 3'b100, 32'h30, 32'h0, 32'h0, 1'b1, 1, 0);

        $display("[TB] assorted sizes and lanes");
        setMem(1'b1, 1'b1, 1'b0, 32'h30, 4'b0010, 32'h3456_A500, 0, 32'h0);
        runAccess(1'b1, 3'b000, 32'h31, 32'h1234_56A5, 32'h0, 1'b0, 2, 1);
        setMem(1'b1, 1'b0, 1'b0, 32'h44, 4'h0, 32'h0, 0, 32'h8001_7FFF);
        runAccess(1'b0, 3'b001, 32'h46, 32'h0, 32'hFFFF_8001, 1'b0, 2, 1);
        setMem(1'b1, 1'b0, 1'b0, 32'h50, 4'h0, 32'h0, 1, 32'h0000_F000);
        runAccess(1'b0, 3'b100, 32'h51, 32'h0, 32'h0000_00F0, 1'b0, 3, 2);
        setMem(1'b1, 1'b1, 1'b0, 32'h60, 4'b1111, 32'hCAFE_F00D, 2, 32'h0);
        runAccess(1'b1, 3'b010, 32'h60, 32'hCAFE_F00D, 32'h0, 1'b0, 4, 3);

`ifdef LSU_MISALIGNED_SPLIT_EN
        $display("[TB] split accesses");
        setMem(1'b1, 1'b0, 1'b0, 32'h20, 4'h0, 32'h0, 0, 32'hAABB_CCDD);
        setBeat2(32'h24, 4'h0, 32'h0, 0, 32'h1122_3344);
        runAccess(1'b0, 3'b010, 32'h22, 32'h0, 32'h3344_AABB, 1'b0, 3, 2);
        setMem(1'b1, 1'b1, 1'b0, 32'h40, 4'b1000, 32'h4400_0000, 0, 32'h0);
        setBeat2(32'h44, 4'b0111, 32'h0011_2233, 1, 32'h0);
        runAccess(1'b1, 3'b010, 32'h43, 32'h1122_3344, 32'h0, 1'b0, 4, 3);
        setMem(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 0, 32'h7F00_0000);
        setBeat2(32'h0000_0000, 4'h0, 32'h0, 0, 32'h0000_00FF);
        runAccess(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FF7F, 1'b0, 3, 2);
        setMem(1'b1, 1'b0, 1'b0, 32'h70, 4'h0, 32'h0, 0, 32'h00AB_CD00);
        runAccess(1'b0, 3'b001, 32'h71, 32'h0, 32'hFFFF_ABCD, 1'b0, 2, 1);
`else
        $display("[TB] misaligned faults");
        setMem(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
        runAccess(1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0);
        setMem(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
        runAccess(1'b1, 3'b001, 32'h71, 32'h0000_1234, 32'h0, 1'b1, 1, 0);
`endif

        $display("[TB] back-to-back");
        setMem(1'b1, 1'b0, 1'b0, 32'h80, 4'h0, 32'h0, 0, 32'h0102_0304);
        applyStimulus(1'b0, 3'b010, 32'h80, 32'h0, 32'h0102_0304, 1'b0, 2, acc1);
        applyStimulus(1'b1, 3'b011, 32'h84, 32'h0, 32'h0, 1'b1, 1, acc2);
        waitIdle();
        checkOutput("b2b_accept_gap", acc2 - acc1, 3);

        $display("[TB] reset during access");
        setMem(1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 0, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h90, 32'h0, 32'h0, 1'b0, 2, acc1);
        @(negedge clk);
        checkOutput("pre_reset_mem_req", {31'h0, mem_req}, 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("async_req_ready", {31'h0, req_ready}, 32'h1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_reset_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("post_reset_req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("post_reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);

        setMem(1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h80FF_0000);
        runAccess(1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
- Multi-cycle load/store controller between the core's memory stage and the data-memory port.
- Accepts one request per handshake and decodes func3 (byte/half/word, signed/unsigned).
- Drives a req/ack memory handshake with word-aligned addresses and byte strobes.
- Aligns and sign/zero-extends load data, then returns one response per request, with a fault flag on bad access or timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for mem_ack before faulting; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1=store, 0=load
- req_func3  in  3  RV32I func3 of the load/store
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  qualified by rsp_valid
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address (bits[1:0]=0)
- mem_wstrb  out  4  byte strobes; 0 for reads
- mem_wdata  out  32  lane-positioned store data
- mem_ack  in  1  access done; rdata valid same cycle
- mem_rdata  in  32  read word

Behaviour:
- Reset: asynchronous, active-high. State returns to IDLE. All outputs go to 0 except req_ready=1. The request latch and timeout counter clear.
- Reset mid-access: mem_req drops immediately. Any later mem_ack is ignored.
- States: IDLE, ACCESS, ACCESS2 (split feature only), RESP.
- IDLE:
  - The request and its address offset off=addr[1:0] are captured on req_valid & req_ready.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Other func3 values, or a misaligned access (see Optional Feature), go directly to RESP with fault=1 and make no memory access.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req=1 with mem_addr={addr[31:2],2'b00}.
  - Store size mask m = 0001 (byte), 0011 (half) or 1111 (word).
  - mem_wstrb=(m<<off)[3:0] and mem_wdata=wdata<<(8*off) for stores.
  - On mem_ack: capture rdata, then go to RESP, or to ACCESS2 when split.
- Timeout:
  - The counter increments each ACCESS/ACCESS2 cycle without ack and resets per beat.
  - Reaching TIMEOUT_CYCLES drops mem_req and goes to RESP with fault=1.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready is low throughout ACCESS/RESP.
- Load extraction:
  - x = rdata>>(8*off), or the split merge below.
  - LB: sign-extend x[7:0]. LBU: zero-extend x[7:0].
  - LH: sign-extend x[15:0]. LHU: zero-extend x[15:0].
  - LW: x.
- Latency: with ack in the first ACCESS cycle, rsp_valid asserts 2 cycles after the accept edge. Fault without access: 1 cycle.
- mem_ack outside ACCESS/ACCESS2 is ignored.
- Back-to-back: the next request is accepted the cycle after RESP.

Optional Feature:
- Macro LSU_MISALIGNED_SPLIT_EN.
- Without it: halfword with addr[0]=1, or word with addr[1:0]!=0, faults with no memory access.
- With it:
  - Accesses within one word complete in a single beat, e.g. LH at off=1 uses bytes 1-2.
  - Word-crossing accesses (half at off=3; word at off!=0) run two beats: ACCESS at word A, then ACCESS2 at A+4.
  - Beat-2 strobe=(m<<off)[7:4] and wdata=wdata>>(8*(4-off)).
  - Load merge: x=({rdata2,rdata1}>>(8*off))[31:0].
  - A timeout in either beat faults. A beat-1 store write is not rolled back.
  - Address wrap at 0xFFFFFFFC+4 goes to 0x00000000.

Decomposition:
- Package lsu_pkg holds:
  - func3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding.
  - Size-mask function.
- Sub-module lsu_load_align, combinational:
  - Inputs: off, func3, 64-bit read data.
  - Output: extended 32-bit result.

Test Plan:
- LB at 0x103, mem_rdata=0x80FF_0000, ack in 1st cycle -> rsp_data=0xFFFFFF80, fault=0, rsp_valid 2 cycles after accept.
- SH at 0x202, wdata=0x0000_BEEF -> mem_addr=0x200, wstrb=1100, mem_wdata=0xBEEF_0000, rsp_data=0.
- LHU at 0x10, ack after 5 waits, rdata=0x1234_ABCD -> rsp_data=0x0000ABCD; mem_req held 6 cycles.
- LW at 0x20, no ack, TIMEOUT_CYCLES=4 -> mem_req drops after 4 cycles, rsp_fault=1, rsp_data=0.
- func3=011 load, and LW at 0x22 without macro -> fault in 1 cycle, mem_req never asserted. With macro, LW at 0x22 with rdata1=0xAABB_CCDD, rdata2=0x1122_3344 -> reads 0x20 then 0x24, rsp_data=0x3344_AABB.
- Assert reset while mem_req=1, then ack arrives after release -> mem_req=0 asynchronously, no rsp_valid, req_ready=1.
